// File: rtl/tlb_pkg.sv
// tlb_pkg: shared TLB geometry, field widths and packed entry layout.
package tlb_pkg;
  localparam int TLBNUM = 16;
  localparam int IDXW = $clog2(TLBNUM);
  localparam int VPN2W = 19;
  localparam int ASIDW = 8;
  localparam int PFNW = 20;
  localparam int CW = 3;
  typedef struct packed {
    logic [PFNW-1:0] pfn;
    logic [CW-1:0] c;
    logic d;
    logic v;
  } page_t;
  typedef struct packed {
    logic [VPN2W-1:0] vpn2;
    logic [ASIDW-1:0] asid;
    logic g;
    page_t p0;
    page_t p1;
  } entry_t;
endpackage

// File: rtl/tlb_search_port.sv
// tlb_search_port: associative match of one query against all entries, lowest hit wins.
module tlb_search_port
  import tlb_pkg::*;
(
  input  logic [TLBNUM-1:0][VPN2W-1:0] vpn2_i,
  input  logic [TLBNUM-1:0][ASIDW-1:0] asid_i,
  input  logic [TLBNUM-1:0]            g_i,
  input  logic [VPN2W-1:0]             q_vpn2_i,
  input  logic [ASIDW-1:0]             q_asid_i,
  output logic [TLBNUM-1:0]            match_o,
  output logic                         found_o,
  output logic [IDXW-1:0]              index_o
);
  always_comb begin
    match_o = '0;
    index_o = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      match_o[i] = (vpn2_i[i] == q_vpn2_i) && (g_i[i] || asid_i[i] == q_asid_i);
      if (match_o[i]) index_o = i[IDXW-1:0];
    end
  end
  assign found_o = |match_o;
endmodule

// File: rtl/tlb.sv
// tlb: 16-entry fully associative MIPS32 TLB with two search ports, one write and one read port.
module tlb
  import tlb_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [VPN2W-1:0] s0_vpn2,
  input  logic             s0_odd_page,
  input  logic [ASIDW-1:0] s0_asid,
  output logic             s0_found,
  output logic [IDXW-1:0]  s0_index,
  output logic [PFNW-1:0]  s0_pfn,
  output logic [CW-1:0]    s0_c,
  output logic             s0_d,
  output logic             s0_v,
  input  logic [VPN2W-1:0] s1_vpn2,
  input  logic             s1_odd_page,
  input  logic [ASIDW-1:0] s1_asid,
  output logic             s1_found,
  output logic [IDXW-1:0]  s1_index,
  output logic [PFNW-1:0]  s1_pfn,
  output logic [CW-1:0]    s1_c,
  output logic             s1_d,
  output logic             s1_v,
  input  logic             we,
  input  logic [IDXW-1:0]  w_index,
  input  logic [VPN2W-1:0] w_vpn2,
  input  logic [ASIDW-1:0] w_asid,
  input  logic             w_g,
  input  logic [PFNW-1:0]  w_pfn0,
  input  logic [CW-1:0]    w_c0,
  input  logic             w_d0,
  input  logic             w_v0,
  input  logic [PFNW-1:0]  w_pfn1,
  input  logic [CW-1:0]    w_c1,
  input  logic             w_d1,
  input  logic             w_v1,
  input  logic [IDXW-1:0]  r_index,
  output logic [VPN2W-1:0] r_vpn2,
  output logic [ASIDW-1:0] r_asid,
  output logic             r_g,
  output logic [PFNW-1:0]  r_pfn0,
  output logic [CW-1:0]    r_c0,
  output logic             r_d0,
  output logic             r_v0,
  output logic [PFNW-1:0]  r_pfn1,
  output logic [CW-1:0]    r_c1,
  output logic             r_d1,
  output logic             r_v1
);
  logic [TLBNUM-1:0][VPN2W-1:0] vpn2_q;
  logic [TLBNUM-1:0][ASIDW-1:0] asid_q;
  logic [TLBNUM-1:0]            g_q;
  logic [TLBNUM-1:0][PFNW-1:0]  pfn0_q, pfn1_q;
  logic [TLBNUM-1:0][CW-1:0]    c0_q, c1_q;
  logic [TLBNUM-1:0]            d0_q, d1_q, v0_q, v1_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      vpn2_q <= '0;
      asid_q <= '0;
      g_q    <= '0;
      pfn0_q <= '0;
      c0_q   <= '0;
      d0_q   <= '0;
      v0_q   <= '0;
      pfn1_q <= '0;
      c1_q   <= '0;
      d1_q   <= '0;
      v1_q   <= '0;
    end else if (we) begin
      vpn2_q[w_index] <= w_vpn2;
      asid_q[w_index] <= w_asid;
      g_q[w_index]    <= w_g;
      pfn0_q[w_index] <= w_pfn0;
      c0_q[w_index]   <= w_c0;
      d0_q[w_index]   <= w_d0;
      v0_q[w_index]   <= w_v0;
      pfn1_q[w_index] <= w_pfn1;
      c1_q[w_index]   <= w_c1;
      d1_q[w_index]   <= w_d1;
      v1_q[w_index]   <= w_v1;
    end
  logic [1:0][VPN2W-1:0]  q_vpn2;
  logic [1:0][ASIDW-1:0]  q_asid;
  logic [1:0]             q_odd, found;
  logic [1:0][IDXW-1:0]   idx;
  logic [1:0][TLBNUM-1:0] match;
  page_t [1:0]            pg;
  assign q_vpn2 = {s1_vpn2, s0_vpn2};
  assign q_asid = {s1_asid, s0_asid};
  assign q_odd  = {s1_odd_page, s0_odd_page};
  for (genvar k = 0; k < 2; k++) begin : g_port
    page_t e0, e1;
    tlb_search_port u_sp (
      .vpn2_i  (vpn2_q),
      .asid_i  (asid_q),
      .g_i     (g_q),
      .q_vpn2_i(q_vpn2[k]),
      .q_asid_i(q_asid[k]),
      .match_o (match[k]),
      .found_o (found[k]),
      .index_o (idx[k])
    );
    assign e0 = '{pfn0_q[idx[k]], c0_q[idx[k]], d0_q[idx[k]], v0_q[idx[k]]};
    assign e1 = '{pfn1_q[idx[k]], c1_q[idx[k]], d1_q[idx[k]], v1_q[idx[k]]};
    // a miss leaves idx at 0, so the page fields are forced to zero unless that entry really hit
    assign pg[k] = !match[k][idx[k]] ? '0 : q_odd[k] ? e1 : e0;
  end
  assign s0_found = found[0];
  assign s0_index = idx[0];
  assign {s0_pfn, s0_c, s0_d, s0_v} = pg[0];
  assign s1_found = found[1];
  assign s1_index = idx[1];
  assign {s1_pfn, s1_c, s1_d, s1_v} = pg[1];
  assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} =
    {vpn2_q[r_index], asid_q[r_index], g_q[r_index], pfn0_q[r_index], c0_q[r_index],
     d0_q[r_index], v0_q[r_index], pfn1_q[r_index], c1_q[r_index], d1_q[r_index], v1_q[r_index]};
endmodule

// File: tb/tb_tlb.sv
// tb_tlb: directed stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_tlb;
  logic clk = 0, resetn = 0;
  logic [18:0] s0_vpn2 = '0, s1_vpn2 = '0, w_vpn2 = '0, r_vpn2;
  logic [7:0] s0_asid = '0, s1_asid = '0, w_asid = '0, r_asid;
  logic s0_odd_page = 0, s1_odd_page = 0, s0_found, s1_found, s0_d, s0_v, s1_d, s1_v;
  logic [3:0] s0_index, s1_index, w_index = '0, r_index = '0;
  logic [19:0] s0_pfn, s1_pfn, w_pfn0 = '0, w_pfn1 = '0, r_pfn0, r_pfn1;
  logic [2:0] s0_c, s1_c, w_c0 = '0, w_c1 = '0, r_c0, r_c1;
  logic we = 0, w_g = 0, w_d0 = 0, w_v0 = 0, w_d1 = 0, w_v1 = 0;
  logic r_g, r_d0, r_v0, r_d1, r_v1;
  tlb dut (
    .clk(clk), .resetn(resetn),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid), .s0_found(s0_found),
    .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid), .s1_found(s1_found),
    .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );
  always #5 clk = ~clk;
  typedef struct {
    string nm;
    int kind;
    logic [77:0] val;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [77:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.kind == 0 ? {48'b0, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} :
            e.kind == 1 ? {48'b0, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} :
            {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.nm, act, e.val);
      end
    end
  end
  task automatic qs(input int p, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid,
                    input logic f, input logic [3:0] ix, input logic [19:0] pfn, input logic [2:0] c,
                    input logic d, input logic v, input string nm);
    exp_t e;
    if (p == 0) begin s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid; end
    else begin s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid; end
    e.nm = nm; e.kind = p; e.val = {48'b0, f, ix, pfn, c, d, v};
    sb.push_back(e);
  endtask
  task automatic qr(input logic [3:0] ix, input logic [77:0] val, input string nm);
    exp_t e;
    r_index = ix;
    e.nm = nm; e.kind = 2; e.val = val;
    sb.push_back(e);
  endtask
  task automatic wr(input logic [3:0] ix, input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                    input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                    input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    we = 1; w_index = ix; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask
  task automatic nx();
    @(posedge clk);
    #1 we = 0;
  endtask
  localparam logic [77:0] E3 = {19'h12345, 8'h05, 1'b0, 20'hAAAAA, 3'd2, 1'b0, 1'b1,
                                20'hBBBBB, 3'd3, 1'b1, 1'b1};
  localparam logic [77:0] E3G = E3 | (78'd1 << 50);
  initial begin
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    qs(0, 19'h12345, 0, 8'h05, 0, 0, 0, 0, 0, 0, "rst_miss");
    qs(1, 19'h0, 0, 8'h00, 1, 0, 0, 0, 0, 0, "rst_zero_hit");
    qr(3, '0, "rst_read");
    nx();
    wr(3, 19'h12345, 8'h05, 0, 20'hAAAAA, 3'd2, 0, 1, 20'hBBBBB, 3'd3, 1, 1);
    qs(1, 19'h12345, 0, 8'h05, 0, 0, 0, 0, 0, 0, "wr_cycle_miss");
    qr(3, '0, "wr_cycle_read_old");
    nx();
    qs(1, 19'h12345, 0, 8'h05, 1, 3, 20'hAAAAA, 3'd2, 0, 1, "hit_even");
    qs(0, 19'h12345, 1, 8'h05, 1, 3, 20'hBBBBB, 3'd3, 1, 1, "hit_odd");
    qr(3, E3, "read3");
    nx();
    qs(0, 19'h12345, 0, 8'h06, 0, 0, 0, 0, 0, 0, "asid_miss");
    nx();
    wr(3, 19'h12345, 8'h05, 1, 20'hAAAAA, 3'd2, 0, 1, 20'hBBBBB, 3'd3, 1, 1);
    qr(3, E3, "rw_same_cycle_old");
    qs(1, 19'h12345, 0, 8'h06, 0, 0, 0, 0, 0, 0, "pre_global_miss");
    nx();
    qr(3, E3G, "rw_next_new");
    qs(0, 19'h12345, 0, 8'h06, 1, 3, 20'hAAAAA, 3'd2, 0, 1, "global_hit");
    qs(1, 19'h12345, 1, 8'hFF, 1, 3, 20'hBBBBB, 3'd3, 1, 1, "global_hit_odd");
    nx();
    wr(9, 19'h00ABC, 8'h11, 0, 20'h11111, 3'd1, 0, 1, 20'h0, 3'd0, 0, 0);
    nx();
    qs(0, 19'h00ABC, 0, 8'h11, 1, 9, 20'h11111, 3'd1, 0, 1, "dup_before");
    wr(4, 19'h00ABC, 8'h11, 0, 20'h44444, 3'd4, 1, 1, 20'h0, 3'd0, 0, 0);
    nx();
    qs(0, 19'h00ABC, 0, 8'h11, 1, 4, 20'h44444, 3'd4, 1, 1, "dup_s0");
    qs(1, 19'h00ABC, 1, 8'h11, 1, 4, 20'h0, 3'd0, 0, 0, "dup_s1_odd");
    nx();
    qs(1, 19'h00ABC, 0, 8'h11, 1, 4, 20'h44444, 3'd4, 1, 1, "dup_s1");
    nx();
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 19'(32'h40000 + i), 8'(i), 0, 20'(32'h1000 + i), 3'(i), 0, 1,
         20'(32'h2000 + i), 3'd0, 1, 1);
      nx();
    end
    qs(0, 19'h4000F, 0, 8'd15, 1, 15, 20'h0100F, 3'd7, 0, 1, "fill15");
    qs(1, 19'h40007, 1, 8'd7, 1, 7, 20'h02007, 3'd0, 1, 1, "fill7_odd");
    qr(0, {19'h40000, 8'h00, 1'b0, 20'h01000, 3'd0, 1'b0, 1'b1, 20'h02000, 3'd0, 1'b1, 1'b1}, "fill_read0");
    nx();
    wr(5, 19'h7FFFF, 8'hAA, 1, 20'hFFFFF, 3'd7, 1, 1, 20'hFFFFF, 3'd7, 1, 1);
    #2 resetn = 0;
    qr(5, '0, "async_rst_read");
    qs(0, 19'h4000F, 0, 8'd15, 0, 0, 0, 0, 0, 0, "async_rst_miss");
    qs(1, 19'h0, 0, 8'h00, 1, 0, 0, 0, 0, 0, "async_rst_zero_hit");
    nx();
    resetn = 1;
    qr(5, '0, "write_discarded");
    qs(0, 19'h7FFFF, 0, 8'hAA, 0, 0, 0, 0, 0, 0, "discarded_miss");
    nx();
    nx();
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
